trace_capture_buffer: RTL and testbench

TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

---
 rtl/trace_capture_buffer_pkg.sv | 56 +++++
 rtl/trace_capture_buffer_ram.sv | 25 ++
 rtl/trace_capture_buffer.sv | 118 +++++++++++
 tb/tb_trace_capture_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_buffer_pkg.sv
// Shared types for the trace capture buffer: sampled machine-cycle entry,
// capture FSM states, bundled status view and the trigger-match helper.
package trace_package;

  localparam int TRACE_ADDR_W  = 16;
  localparam int TRACE_DATA_W  = 8;
  localparam int TRACE_STATE_W = 24;
  localparam int TRACE_COUNT_W = 5;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0]  address_bus;
    logic [TRACE_DATA_W-1:0]  data_bus;
    logic [TRACE_DATA_W-1:0]  instruction_reg;
    logic [TRACE_STATE_W-1:0] fsm_state;
    logic                     carry;
    logic                     sign;
    logic                     zero;
    logic                     mem_read;
    logic                     mem_write;
    logic                     halt;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_NONE  = 2'd0,
    TRIG_HALT  = 2'd1,
    TRIG_ADDR  = 2'd2,
    TRIG_WRITE = 2'd3
  } trig_mode_t;

  typedef struct packed {
    logic                     rd_valid;
    trace_entry_t             rd_data;
    logic [TRACE_COUNT_W-1:0] count;
    trace_state_t             state;
    logic                     overflow;
  } output_struct;

  function automatic logic trigger_hit(input trig_mode_t mode,
                                       input trace_entry_t entry,
                                       input logic [TRACE_ADDR_W-1:0] addr);
    case (mode)
      TRIG_HALT:  return entry.halt;
      TRIG_ADDR:  return entry.address_bus == addr;
      TRIG_WRITE: return entry.mem_write;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trace_capture_buffer_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one
// asynchronous read port so the head entry is visible with zero latency.
module trace_ring_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 62
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers/count,
  // which lets the array map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Trigger-based trace capture: rings machine-cycle samples until a trigger,
// keeps POST_TRIG further entries, then lets a consumer drain them in order.
module trace_capture_buffer
  import trace_package::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int ADDR_W    = TRACE_ADDR_W,
  parameter int DATA_W    = TRACE_DATA_W,
  parameter int STATE_W   = TRACE_STATE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     clear,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        trig_addr,
  input  logic                     snap_valid,
  input  trace_entry_t             snap_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output trace_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ADDR_W + 2 * DATA_W + STATE_W + 6;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);
  localparam ptr_t POST_LOAD  = ptr_t'(POST_TRIG);

  trace_state_t      state_q;
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  ptr_t              post_cnt;
  cnt_t              count_q;
  logic              overflow_q;
  logic              wr_en;
  logic              pop;
  logic              trig;
  logic [ENTRY_W-1:0] ram_rd;

  // arm/clear take priority over any same-cycle write or pop.
  assign wr_en    = snap_valid && (state_q == ARMED || state_q == CAPTURE) && !arm && !clear;
  assign rd_valid = (state_q == IDLE || state_q == DONE) && (count_q != '0);
  assign pop      = rd_valid && rd_ready && !arm && !clear;
  assign trig     = (state_q == ARMED) && trigger_hit(trig_mode_t'(mode), snap_in, trig_addr);

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear || arm) begin
      state_q    <= clear ? IDLE : ARMED;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
        if (count_q == FULL_COUNT) begin
          rd_ptr     <= rd_ptr + ptr_t'(1);
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + cnt_t'(1);
        end
        if (trig) begin
          if (POST_TRIG == 0) begin
            state_q <= DONE;
          end else begin
            state_q  <= CAPTURE;
            post_cnt <= POST_LOAD;
          end
        end else if (state_q == CAPTURE) begin
          post_cnt <= post_cnt - ptr_t'(1);
          if (post_cnt == ptr_t'(1)) state_q <= DONE;
        end
      end
      // Writes and pops never coincide: they are enabled in disjoint states.
      if (pop) begin
        rd_ptr  <= rd_ptr + ptr_t'(1);
        count_q <= count_q - cnt_t'(1);
        if (count_q == cnt_t'(1) && state_q == DONE) state_q <= IDLE;
      end
    end
  end

  trace_ring_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (snap_in),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd)
  );

  assign rd_data  = trace_entry_t'(ram_rd);
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench: a vector table for the basic capture/drain flow plus
// hand-written sequences for wrap, POST_TRIG=0, drain and reset corners.
module tb_trace_capture_buffer;
  import trace_package::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         arm, clear, snap_valid, rd_ready;
  logic [1:0]   mode;
  logic [15:0]  trig_addr;
  trace_entry_t snap_in;

  logic         rd_valid, rd_valid0;
  trace_entry_t rd_data, rd_data0;
  logic [4:0]   count, count0;
  logic [1:0]   state, state0;
  logic         overflow, overflow0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trace_capture_buffer u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .mode(mode),
    .trig_addr(trig_addr), .snap_valid(snap_valid), .snap_in(snap_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .state(state), .overflow(overflow)
  );

  trace_capture_buffer #(.POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .clear(clear), .mode(mode),
    .trig_addr(trig_addr), .snap_valid(snap_valid), .snap_in(snap_in),
    .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_data(rd_data0),
    .count(count0), .state(state0), .overflow(overflow0)
  );

  typedef struct {
    logic        arm, clear;
    logic [1:0]  mode;
    logic        sv;
    logic [15:0] addr;
    logic        halt, mw, rdy;
    logic [1:0]  e_state;
    logic [4:0]  e_count;
    logic        e_valid, e_ov, chk_data;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic c, input logic [1:0] m, input logic sv,
                       input logic [15:0] addr, input logic h, input logic w, input logic r);
    arm = a; clear = c; mode = m; snap_valid = sv; rd_ready = r;
    snap_in = '{address_bus: addr, data_bus: addr[7:0], instruction_reg: ~addr[7:0],
                fsm_state: 24'h1 << addr[4:0], carry: addr[0], sign: addr[1], zero: addr[2],
                mem_read: ~w, mem_write: w, halt: h};
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, mode, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic a, input logic c, input logic [1:0] m, input logic sv,
                              input logic [15:0] addr, input logic w, input logic r,
                              input logic [1:0] es, input logic [4:0] ec, input logic ev,
                              input logic cd, input logic [15:0] ea);
    vec_t v;
    v = '{arm: a, clear: c, mode: m, sv: sv, addr: addr, halt: 1'b0, mw: w, rdy: r,
          e_state: es, e_count: ec, e_valid: ev, e_ov: 1'b0, chk_data: cd, e_addr: ea};
    return v;
  endfunction

  logic [15:0] exp_addr;

  initial begin
    rst_n = 1'b0;
    trig_addr = 16'h0040;
    mode = 2'd0;
    idle_inputs();

    // Mode 3 (MemWrite) capture, retrigger ignored, drain two, re-arm, arm+clear.
    vecs[0]  = mk(0, 0, 2'd0, 0, 16'h00, 0, 0, 2'd0, 5'd0, 0, 0, 16'h0);
    vecs[1]  = mk(1, 0, 2'd3, 0, 16'h00, 0, 0, 2'd1, 5'd0, 0, 0, 16'h0);
    vecs[2]  = mk(0, 0, 2'd3, 1, 16'hA0, 0, 0, 2'd1, 5'd1, 0, 0, 16'h0);
    vecs[3]  = mk(0, 0, 2'd3, 1, 16'hA1, 1, 0, 2'd2, 5'd2, 0, 0, 16'h0);
    vecs[4]  = mk(0, 0, 2'd3, 1, 16'hA2, 1, 0, 2'd2, 5'd3, 0, 0, 16'h0);
    vecs[5]  = mk(0, 0, 2'd3, 0, 16'h00, 0, 0, 2'd2, 5'd3, 0, 0, 16'h0);
    vecs[6]  = mk(0, 0, 2'd3, 1, 16'hA3, 0, 0, 2'd2, 5'd4, 0, 0, 16'h0);
    vecs[7]  = mk(0, 0, 2'd3, 1, 16'hA4, 0, 0, 2'd2, 5'd5, 0, 0, 16'h0);
    vecs[8]  = mk(0, 0, 2'd3, 1, 16'hA5, 0, 0, 2'd3, 5'd6, 1, 1, 16'hA0);
    vecs[9]  = mk(0, 0, 2'd3, 1, 16'hA6, 0, 0, 2'd3, 5'd6, 1, 1, 16'hA0);
    vecs[10] = mk(0, 0, 2'd3, 0, 16'h00, 0, 1, 2'd3, 5'd5, 1, 1, 16'hA1);
    vecs[11] = mk(0, 0, 2'd3, 0, 16'h00, 0, 1, 2'd3, 5'd4, 1, 1, 16'hA2);
    vecs[12] = mk(1, 0, 2'd3, 0, 16'h00, 0, 0, 2'd1, 5'd0, 0, 0, 16'h0);
    vecs[13] = mk(1, 1, 2'd3, 0, 16'h00, 0, 0, 2'd0, 5'd0, 0, 0, 16'h0);

    #12;
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].arm, vecs[i].clear, vecs[i].mode, vecs[i].sv, vecs[i].addr,
            vecs[i].halt, vecs[i].mw, vecs[i].rdy);
      tick();
      check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ov));
      if (vecs[i].chk_data)
        check($sformatf("v%0d_data", i), 32'(rd_data.address_bus), 32'(vecs[i].e_addr));
    end

    // Address-match capture with 10 pre-trigger samples, then full drain.
    drive(1, 0, 2'd2, 0, 16'h0, 0, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 2'd2, 1, 16'h30 + 16'(i), 0, 0, 0); tick();
    end
    check("addr_pre_state", 32'(state), 32'd1);
    drive(0, 0, 2'd2, 1, 16'h40, 0, 0, 0); tick();
    check("addr_trig_state", 32'(state), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 2'd2, 1, 16'h40 + 16'(i), 0, 0, 0); tick();
    end
    idle_inputs();
    check("addr_done_state", 32'(state), 32'd3);
    check("addr_done_count", 32'(count), 32'd15);
    check("addr_done_ovf", 32'(overflow), 32'd0);
    check("addr_first_pop", 32'(rd_data.address_bus), 32'h30);
    rd_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_addr = (i < 10) ? 16'h30 + 16'(i) : 16'h40 + 16'(i - 10);
      check($sformatf("drain%0d_valid", i), 32'(rd_valid), 32'd1);
      check($sformatf("drain%0d_data", i), 32'(rd_data.address_bus), 32'(exp_addr));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_end_state", 32'(state), 32'd0);
    check("drain_end_valid", 32'(rd_valid), 32'd0);

    // Mode 0: never triggers, wraps and flags overflow; no reads while ARMED.
    drive(1, 0, 2'd0, 0, 16'h0, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 2'd0, 1, 16'(i), 1, 1, 1); tick();
    end
    idle_inputs();
    rd_ready = 1'b1;
    tick();
    check("wrap_state", 32'(state), 32'd1);
    check("wrap_count", 32'(count), 32'd16);
    check("wrap_ovf", 32'(overflow), 32'd1);
    check("wrap_no_read", 32'(rd_valid), 32'd0);
    drive(0, 1, 2'd0, 0, 16'h0, 0, 0, 0); tick();
    idle_inputs();
    check("clear_state", 32'(state), 32'd0);
    check("clear_count", 32'(count), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);

    // POST_TRIG=0 instance: Halt on third sample ends capture immediately.
    drive(1, 0, 2'd1, 0, 16'h0, 0, 0, 0); tick();
    drive(0, 0, 2'd1, 1, 16'h10, 0, 0, 0); tick();
    drive(0, 0, 2'd1, 1, 16'h11, 0, 0, 0); tick();
    check("p0_pre_state", 32'(state0), 32'd1);
    drive(0, 0, 2'd1, 1, 16'h12, 1, 0, 0); tick();
    check("p0_done_state", 32'(state0), 32'd3);
    check("p0_done_count", 32'(count0), 32'd3);
    drive(0, 0, 2'd1, 1, 16'h13, 0, 0, 0); tick();
    check("p0_no_store", 32'(count0), 32'd3);
    check("p0_head", 32'(rd_data0.address_bus), 32'h10);
    drive(0, 0, 2'd1, 0, 16'h0, 0, 0, 1); tick();
    check("p0_two_left", 32'(count0), 32'd2);
    check("p0_pop_a", 32'(rd_data0.address_bus), 32'h11);
    tick();
    check("p0_pop_b", 32'(rd_data0.address_bus), 32'h12);
    check("p0_one_left", 32'(count0), 32'd1);
    tick();
    check("p0_idle_state", 32'(state0), 32'd0);
    check("p0_idle_valid", 32'(rd_valid0), 32'd0);
    check("p0_idle_count", 32'(count0), 32'd0);
    idle_inputs();

    // Asynchronous reset in the middle of CAPTURE discards the capture.
    drive(1, 0, 2'd2, 0, 16'h0, 0, 0, 0); tick();
    drive(0, 0, 2'd2, 1, 16'h40, 0, 0, 0); tick();
    drive(0, 0, 2'd2, 1, 16'h41, 0, 0, 0); tick();
    drive(0, 0, 2'd2, 1, 16'h42, 0, 0, 0); tick();
    idle_inputs();
    check("rst_pre_state", 32'(state), 32'd2);
    check("rst_pre_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_count", 32'(count), 32'd0);
    check("rst_async_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_after_state", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
